// File: rtl/prog_interval_counter.sv
// Programmable interval counter: loads a value from the switch interface,
// then counts it down to zero, up to it, or free-runs, one step per
// prescaled tick. Start/pause/resume control with tick and done strobes.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | loaded or reset, waiting for start
// S_RUN   | prescaler advancing, count steps on each tick
// S_PAUSE | counting suspended, count and prescaler frozen
// S_DONE  | terminal count reached, count holds, waiting for load/start
module prog_interval_counter #(
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load,
    input  logic             start,
    input  logic             pause,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tick,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
    localparam logic [1:0]       MODE_UP    = 2'b01;
    localparam logic [1:0]       MODE_FREE  = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;

    logic             tick_w;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;

    assign tick_w    = (state_q == S_RUN) && (presc_q == PRESC_LAST);
    assign count_inc = count_q + CNT_ONE;
    assign count_dec = count_q - CNT_ONE;

    // Next-state, counting and strobe logic; load > start > pause outside RUN,
    // only pause has any effect inside RUN.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        presc_d  = presc_q;
        mode_d   = mode_q;
        done_d   = 1'b0;

        case (state_q)
            S_RUN: begin
                if (tick_w) begin
                    presc_d = '0;
                end else if (!pause) begin
                    presc_d = presc_q + 1'b1;
                end

                if (pause) begin
                    state_d = S_PAUSE;
                end

                // A terminal step wins over a coincident pause.
                if (tick_w) begin
                    case (mode_q)
                        MODE_UP: begin
                            count_d = count_inc;
                            if (count_inc == target_q) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end
                        MODE_FREE: begin
                            count_d = count_inc;
                            if (count_q == CNT_MAX) begin
                                done_d = 1'b1;
                            end
                        end
                        default: begin
                            count_d = count_dec;
                            if (count_q == CNT_ONE) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    endcase
                end
            end

            default: begin
                if (load) begin
                    target_d = load_val;
                    count_d  = load_val;
                    presc_d  = '0;
                    state_d  = S_IDLE;
                end else if (start) begin
                    if (state_q == S_PAUSE) begin
                        state_d = S_RUN;
                    end else begin
                        mode_d  = mode;
                        presc_d = '0;
                        if ((mode == MODE_UP) || (mode == MODE_FREE)) begin
                            count_d = '0;
                        end else begin
                            count_d = target_q;
                        end
                        // Nothing to count towards: finish without a tick.
                        if ((mode != MODE_FREE) && (target_q == '0)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            target_q <= '0;
            presc_q  <= '0;
            mode_q   <= 2'b00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            presc_q  <= presc_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    assign count   = count_q;
    assign running = (state_q == S_RUN);
    assign tick    = tick_w;
    assign done    = done_q;

endmodule

// File: tb/tb_prog_interval_counter.sv
module tb_prog_interval_counter;

    localparam int W  = 8;
    localparam int TD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] load_val;
    logic         load, start, pause;
    logic [1:0]   mode;
    logic [W-1:0] count;
    logic         running, tick, done;

    int total = 0;
    int bad   = 0;

    prog_interval_counter #(.WIDTH(W), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .load_val(load_val), .load(load), .start(start),
        .pause(pause), .mode(mode), .count(count), .running(running),
        .tick(tick), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: spec-level state, value and elapsed cycles since last step.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_state, m_count, m_target, m_mode, m_phase;
    bit m_done;

    task automatic model_reset();
        m_state = M_IDLE; m_count = 0; m_target = 0; m_mode = 0; m_phase = 0; m_done = 0;
    endtask

    function automatic logic [W+2:0] exp_vec();
        return {W'(m_count), m_state == M_RUN, (m_state == M_RUN) && (m_phase == TD - 1), m_done};
    endfunction

    task automatic model_edge();
        bit nd = 0;
        if (m_state == M_RUN) begin
            if (m_phase == TD - 1) begin
                m_phase = 0;
                if (m_mode == 1) begin
                    m_count = m_count + 1;
                    if (m_count == m_target) begin m_state = M_DONE; nd = 1; end
                end else if (m_mode == 2) begin
                    m_count = (m_count + 1) % (1 << W);
                    if (m_count == 0) nd = 1;
                end else begin
                    m_count = m_count - 1;
                    if (m_count == 0) begin m_state = M_DONE; nd = 1; end
                end
            end else if (!pause) begin
                m_phase = m_phase + 1;
            end
            if (pause && m_state == M_RUN) m_state = M_PAUSE;
        end else if (load) begin
            m_target = int'(load_val); m_count = int'(load_val); m_phase = 0; m_state = M_IDLE;
        end else if (start) begin
            if (m_state == M_PAUSE) begin
                m_state = M_RUN;
            end else begin
                m_mode  = int'(mode);
                m_phase = 0;
                m_count = (mode == 2'b01 || mode == 2'b10) ? 0 : m_target;
                if (mode != 2'b10 && m_target == 0) begin m_state = M_DONE; nd = 1; end
                else m_state = M_RUN;
            end
        end
        m_done = nd;
    endtask

    // Advance model and DUT one edge; strobes drop after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 0; start = 0; pause = 0; mode = 2'b00; load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (count !== 8'h00) begin bad++; $display("FAIL reset_count act=%h exp=00", count); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running act=%b exp=0", running); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick act=%b exp=0", tick); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done act=%b exp=0", done); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_down();
        int ticks[$];
        int dones[$];
        load_val = 8'd5; load = 1; step();
        total++; if (count !== 8'd5) begin bad++; $display("FAIL down_load act=%0d exp=5", count); end
        mode = 2'b00; start = 1; step();
        for (int cy = 0; cy < 30; cy++) begin
            total++;
            if ({count, running, tick, done} !== exp_vec()) begin
                bad++; $display("FAIL down_cyc%0d act=%h exp=%h", cy, {count, running, tick, done}, exp_vec());
            end
            if (tick) ticks.push_back(cy);
            if (done) dones.push_back(cy);
            step();
        end
        total++; if (ticks.size() != 5) begin bad++; $display("FAIL down_nticks act=%0d exp=5", ticks.size()); end
        for (int i = 0; i < ticks.size() && i < 5; i++) begin
            total++; if (ticks[i] != 3 + 4 * i) begin bad++; $display("FAIL down_tick%0d act=%0d exp=%0d", i, ticks[i], 3 + 4 * i); end
        end
        total++; if (dones.size() != 1 || dones[0] != 20) begin bad++; $display("FAIL down_done n=%0d exp one pulse at 20", dones.size()); end
        total++; if (count !== 8'd0 || running !== 1'b0) begin bad++; $display("FAIL down_final act=%0d/%b exp=0/0", count, running); end
    endtask

    task automatic test_up();
        int ticks[$];
        int dones[$];
        load_val = 8'd3; load = 1; step();
        mode = 2'b01; start = 1; step();
        total++; if (count !== 8'd0) begin bad++; $display("FAIL up_start act=%0d exp=0", count); end
        for (int cy = 0; cy < 20; cy++) begin
            total++;
            if ({count, running, tick, done} !== exp_vec()) begin
                bad++; $display("FAIL up_cyc%0d act=%h exp=%h", cy, {count, running, tick, done}, exp_vec());
            end
            if (tick) ticks.push_back(cy);
            if (done) dones.push_back(cy);
            step();
        end
        total++; if (ticks.size() != 3 || ticks[0] != 3 || ticks[2] != 11) begin bad++; $display("FAIL up_ticks n=%0d exp 3 at 3,7,11", ticks.size()); end
        total++; if (dones.size() != 1 || dones[0] != 12) begin bad++; $display("FAIL up_done n=%0d exp one pulse at 12", dones.size()); end
        total++; if (count !== 8'd3 || running !== 1'b0) begin bad++; $display("FAIL up_final act=%0d/%b exp=3/0", count, running); end
    endtask

    task automatic test_free_wrap();
        int dones[$];
        logic [W-1:0] cnt_at_done = 8'hAA;
        load_val = 8'd77; mode = 2'b10; start = 1; step();
        for (int cy = 0; cy < 1040; cy++) begin
            total++;
            if ({count, running, tick, done} !== exp_vec()) begin
                bad++; $display("FAIL free_cyc%0d act=%h exp=%h", cy, {count, running, tick, done}, exp_vec());
            end
            if (cy == 500) mode = 2'b00;
            if (done) begin dones.push_back(cy); cnt_at_done = count; end
            step();
        end
        total++; if (dones.size() != 1 || dones[0] != 1024) begin bad++; $display("FAIL free_done n=%0d exp one pulse at 1024", dones.size()); end
        total++; if (cnt_at_done !== 8'h00) begin bad++; $display("FAIL free_wrapval act=%h exp=00", cnt_at_done); end
        total++; if (running !== 1'b1) begin bad++; $display("FAIL free_running act=%b exp=1", running); end
        pause = 1; step();
        load_val = 8'd0; load = 1; step();
    endtask

    task automatic test_pause_resume();
        bit stuck = 0;
        load_val = 8'd6; load = 1; step();
        mode = 2'b00; start = 1; step();
        for (int cy = 0; cy < 10; cy++) step();
        total++; if (count !== 8'd4) begin bad++; $display("FAIL pause_pre act=%0d exp=4", count); end
        pause = 1; step();
        for (int cy = 0; cy < 20; cy++) begin
            if (count !== 8'd4 || tick !== 1'b0 || running !== 1'b0) stuck = 1;
            step();
        end
        total++; if (stuck) begin bad++; $display("FAIL pause_hold act=%0d tick=%b run=%b exp=4/0/0", count, tick, running); end
        start = 1; step();
        total++; if ({count, tick} !== {8'd4, 1'b0}) begin bad++; $display("FAIL resume_0 act=%0d/%b exp=4/0", count, tick); end
        step();
        total++; if ({count, tick} !== {8'd4, 1'b1}) begin bad++; $display("FAIL resume_1 act=%0d/%b exp=4/1", count, tick); end
        step();
        total++; if (count !== 8'd3) begin bad++; $display("FAIL resume_2 act=%0d exp=3", count); end
        load_val = 8'd99; load = 1; step();
        total++; if (count !== 8'd3 || running !== 1'b1) begin bad++; $display("FAIL run_load act=%0d/%b exp=3/1", count, running); end
        for (int cy = 0; cy < 20; cy++) begin
            total++;
            if ({count, running, tick, done} !== exp_vec()) begin
                bad++; $display("FAIL pause_cyc%0d act=%h exp=%h", cy, {count, running, tick, done}, exp_vec());
            end
            step();
        end
        total++; if (count !== 8'd0 || running !== 1'b0) begin bad++; $display("FAIL pause_final act=%0d/%b exp=0/0", count, running); end
    endtask

    task automatic test_zero_target();
        for (int m = 0; m < 2; m++) begin
            load_val = 8'd0; load = 1; step();
            mode = 2'(m); start = 1; step();
            total++;
            if ({count, running, tick, done} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
                bad++; $display("FAIL zero_m%0d act=%h exp=%h", m, {count, running, tick, done}, {8'd0, 3'b001});
            end
            step();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_m%0d_pulse act=%b exp=0", m, done); end
        end
    endtask

    task automatic test_async_reset();
        load_val = 8'd7; load = 1; step();
        mode = 2'b00; start = 1; step();
        for (int cy = 0; cy < 6; cy++) step();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({count, running, tick, done} !== {8'd0, 3'b000}) begin
            bad++; $display("FAIL async_rst act=%h exp=000", {count, running, tick, done});
        end
        #2 rst = 1'b0;
        model_reset();
        step();
    endtask

    task automatic test_random();
        for (int cy = 0; cy < 3000; cy++) begin
            load     = ($urandom_range(0, 15) == 0);
            start    = ($urandom_range(0, 7) == 0);
            pause    = ($urandom_range(0, 15) == 0);
            mode     = 2'($urandom_range(0, 3));
            load_val = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            total++;
            if ({count, running, tick, done} !== exp_vec()) begin
                bad++; $display("FAIL rand_cyc%0d act=%h exp=%h", cy, {count, running, tick, done}, exp_vec());
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_down();
        test_up();
        test_free_wrap();
        test_pause_resume();
        test_zero_target();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
